// File: rtl/cmd_router_pkg.sv
// Shared types and constants for the host packet router.
// Both the inbound parser and the reply arbiter import this package.
package cmd_router_pkg;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hAA;

    typedef enum logic [1:0] {
        R_SYNC,
        R_ADDR,
        R_LEN,
        R_DATA
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_SYNC,
        T_ADDR,
        T_LEN,
        T_PAY
    } tx_state_t;

endpackage

// File: rtl/cmd_router_msg_arbiter.sv
// Round-robin reply arbiter: picks a slave with a pending message
// and streams [SYNC, ADDR, LEN, payload] on a ready/valid byte link.
module msg_arbiter
    import cmd_router_pkg::*;
#(
    parameter int         N_SLAVES  = 9,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [N_SLAVES-1:0]   have_msg_bus,
    input  logic [8*N_SLAVES-1:0] slave_data_bus,
    input  logic [8*N_SLAVES-1:0] len_bus,
    output logic [N_SLAVES-1:0]   rdreq_bus,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    tx_state_t      state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [7:0]     rem_q, rem_d;
    logic           tx_valid_q, tx_valid_d;

    logic [7:0]     len_a  [N_SLAVES];
    logic [7:0]     data_a [N_SLAVES];
    logic           found;
    logic [IW-1:0]  sel;
    logic [IW-1:0]  j;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_split
        assign len_a[i]  = len_bus[8*i +: 8];
        assign data_a[i] = slave_data_bus[8*i +: 8];
    end

    // First requester after the last one served, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = '0;
        for (int k = 1; k <= N_SLAVES; k++) begin
            j = IW'((int'(ptr_q) + k) % N_SLAVES);
            if (!found && have_msg_bus[j] && len_a[j] != 8'd0) begin
                found = 1'b1;
                sel   = j;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        tx_data   = 8'h00;
        rdreq_bus = '0;
        unique case (state_q)
            T_IDLE: begin
                if (found) begin
                    idx_d   = sel;
                    ptr_d   = sel;
                    rem_d   = len_a[sel];
                    state_d = T_SYNC;
                end
            end
            T_SYNC: begin
                tx_data = SYNC_BYTE;
                if (tx_ready) state_d = T_ADDR;
            end
            T_ADDR: begin
                tx_data = 8'(idx_q);
                if (tx_ready) state_d = T_LEN;
            end
            T_LEN: begin
                tx_data = rem_q;
                if (tx_ready) state_d = T_PAY;
            end
            T_PAY: begin
                tx_data = data_a[idx_q];
                if (tx_ready) begin
                    rdreq_bus[idx_q] = 1'b1;
                    rem_d            = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = T_IDLE;
                end
            end
            default: state_d = T_IDLE;
        endcase
        tx_valid_d = (state_d != T_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= T_IDLE;
            idx_q      <= '0;
            ptr_q      <= IW'(N_SLAVES - 1);
            rem_q      <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_valid = tx_valid_q;

endmodule

// File: rtl/cmd_router.sv
// Host byte-link packet router: parses inbound writes into slave
// strobes and hands outbound replies to the msg_arbiter.
module cmd_router
    import cmd_router_pkg::*;
#(
    parameter int         N_SLAVES   = 9,
    parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
    parameter int         RX_TIMEOUT = 1000
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            master_data,
    output logic [N_SLAVES-1:0]   valid_bus,
    input  logic [N_SLAVES-1:0]   have_msg_bus,
    input  logic [8*N_SLAVES-1:0] slave_data_bus,
    input  logic [8*N_SLAVES-1:0] len_bus,
    output logic [N_SLAVES-1:0]   rdreq_bus,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  err_addr,
    output logic                  err_timeout
);

    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RX_TIMEOUT - 1);
    localparam logic [7:0]    NS8      = 8'(N_SLAVES);

    rx_state_t           state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          rem_q, rem_d;
    logic [7:0]          mdata_q, mdata_d;
    logic [N_SLAVES-1:0] vbus_q, vbus_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                addr_bad;

    assign addr_bad = (addr_q >= NS8);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        mdata_d     = mdata_q;
        vbus_d      = '0;
        tmo_d       = '0;
        err_addr    = 1'b0;
        err_timeout = 1'b0;
        // Idle gaps only matter once a packet has started.
        if (state_q != R_SYNC && !rx_valid) begin
            if (tmo_q == TMO_LAST) begin
                state_d     = R_SYNC;
                err_timeout = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
        if (rx_valid) begin
            unique case (state_q)
                R_SYNC: begin
                    if (rx_data == SYNC_BYTE) state_d = R_ADDR;
                end
                R_ADDR: begin
                    addr_d  = rx_data;
                    state_d = R_LEN;
                end
                R_LEN: begin
                    rem_d    = rx_data;
                    err_addr = addr_bad;
                    state_d  = (rx_data == 8'd0) ? R_SYNC : R_DATA;
                end
                R_DATA: begin
                    rem_d = rem_q - 8'd1;
                    if (!addr_bad) begin
                        mdata_d                 = rx_data;
                        vbus_d[addr_q[IW-1:0]] = 1'b1;
                    end
                    if (rem_q == 8'd1) state_d = R_SYNC;
                end
                default: state_d = R_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= R_SYNC;
            addr_q  <= 8'd0;
            rem_q   <= 8'd0;
            mdata_q <= 8'd0;
            vbus_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            mdata_q <= mdata_d;
            vbus_q  <= vbus_d;
            tmo_q   <= tmo_d;
        end
    end

    assign master_data = mdata_q;
    assign valid_bus   = vbus_q;

    msg_arbiter #(
        .N_SLAVES  (N_SLAVES),
        .SYNC_BYTE (SYNC_BYTE)
    ) u_arb (
        .clk            (clk),
        .n_rst          (n_rst),
        .have_msg_bus   (have_msg_bus),
        .slave_data_bus (slave_data_bus),
        .len_bus        (len_bus),
        .rdreq_bus      (rdreq_bus),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

endmodule

// File: tb/tb_cmd_router.sv
// Scoreboard bench for cmd_router: random and directed rx packets,
// slave reply queues and a round-robin reference for tx traffic.
module tb_cmd_router;

    localparam int         N   = 9;
    localparam int         TMO = 1000;
    localparam logic [7:0] SB  = 8'hAA;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_valid = 1'b0;
    logic [7:0]     master_data;
    logic [N-1:0]   valid_bus;
    logic [N-1:0]   have_msg_bus = '0;
    logic [8*N-1:0] slave_data_bus = '0;
    logic [8*N-1:0] len_bus = '0;
    logic [N-1:0]   rdreq_bus;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b0;
    logic           err_addr;
    logic           err_timeout;

    always #5 clk = ~clk;

    cmd_router #(
        .N_SLAVES   (N),
        .SYNC_BYTE  (SB),
        .RX_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .master_data    (master_data),
        .valid_bus      (valid_bus),
        .have_msg_bus   (have_msg_bus),
        .slave_data_bus (slave_data_bus),
        .len_bus        (len_bus),
        .rdreq_bus      (rdreq_bus),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .err_addr       (err_addr),
        .err_timeout    (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        bit         pay;
        int         slv;
        bit         first;
        bit         last;
    } tx_t;

    wr_t wr_q[$];
    tx_t tx_q[$];
    int  exp_eaddr = 0;
    int  exp_etmo  = 0;
    int  got_eaddr = 0;
    int  got_etmo  = 0;

    // Slave reply stores: bytes and message lengths per slave.
    logic [7:0] sbuf [N][512];
    int         lbuf [N][128];
    int         sh [N];
    int         st [N];
    int         lh [N];
    int         lt [N];
    int         cur [N];
    bit         zl [N];
    int         rr_ptr   = N - 1;
    int         rdy_mode = 2;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic send_pkt(input logic [7:0] a, input int len,
                            input logic [31:0] pl, input bit rnd,
                            input int gmax);
        logic [7:0] d;
        rx_byte(SB, $urandom_range(0, gmax));
        rx_byte(a, $urandom_range(0, gmax));
        if (a >= 8'(N)) exp_eaddr++;
        rx_byte(8'(len), $urandom_range(0, gmax));
        chk("err_addr_pulse", got_eaddr, exp_eaddr);
        for (int i = 0; i < len; i++) begin
            d = rnd ? 8'($urandom) : pl[8*i +: 8];
            if (a < 8'(N)) wr_q.push_back('{addr: a, data: d});
            rx_byte(d, $urandom_range(0, gmax));
        end
    endtask

    function automatic void push_msg(int s, int len, bit rnd,
                                     logic [7:0] b0, logic [7:0] b1);
        for (int i = 0; i < len; i++) begin
            sbuf[s][st[s]] = rnd ? 8'($urandom) : ((i == 0) ? b0 : b1);
            st[s]++;
        end
        lbuf[s][lt[s]] = len;
        lt[s]++;
    endfunction

    // Reference order: serve pending slaves round-robin after the last one.
    function automatic void schedule();
        int mh [N];
        int bh [N];
        int j;
        int len;
        bit any;
        for (int s = 0; s < N; s++) begin
            mh[s] = lh[s];
            bh[s] = sh[s];
        end
        while (1) begin
            any = 1'b0;
            j   = 0;
            for (int k = 1; k <= N; k++) begin
                j = (rr_ptr + k) % N;
                if (!zl[j] && mh[j] != lt[j]) begin
                    any = 1'b1;
                    break;
                end
            end
            if (!any) break;
            rr_ptr = j;
            len    = lbuf[j][mh[j]];
            mh[j]++;
            tx_q.push_back('{b: SB, pay: 0, slv: j, first: 1, last: 0});
            tx_q.push_back('{b: 8'(j), pay: 0, slv: j, first: 0, last: 0});
            tx_q.push_back('{b: 8'(len), pay: 0, slv: j, first: 0, last: 0});
            for (int i = 0; i < len; i++) begin
                tx_q.push_back('{b: sbuf[j][bh[j]], pay: 1, slv: j,
                                 first: 0, last: (i == len - 1)});
                bh[j]++;
            end
        end
    endfunction

    task automatic wait_tx_done();
        int n = 0;
        while (tx_q.size() != 0 && n < 4000) begin
            tick();
            n++;
        end
        chk("tx_drain", tx_q.size(), 0);
        tick();
        tick();
    endtask

    function automatic void update_bus();
        bit pend;
        for (int s = 0; s < N; s++) begin
            pend                     = (lh[s] != lt[s]);
            have_msg_bus[s]          = pend | zl[s];
            len_bus[8*s +: 8]        = pend ? 8'(lbuf[s][lh[s]]) : 8'h00;
            slave_data_bus[8*s +: 8] = (sh[s] != st[s]) ? sbuf[s][sh[s]]
                                                       : 8'h00;
        end
    endfunction

    // Slave FWFT model plus tx_ready pattern.
    always begin : slaves
        logic [N-1:0] pops;
        @(negedge clk);
        pops = rdreq_bus;
        @(posedge clk);
        #1;
        if (!n_rst) pops = '0;
        for (int s = 0; s < N; s++) begin
            if (pops[s] && lh[s] != lt[s]) begin
                sh[s]++;
                cur[s]++;
                if (cur[s] == lbuf[s][lh[s]]) begin
                    lh[s]++;
                    cur[s] = 0;
                end
            end
        end
        update_bus();
        case (rdy_mode)
            0:       tx_ready = 1'($urandom);
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin : mon
        wr_t        w;
        tx_t        t;
        bit         stall_p;
        bit         gap_p;
        logic [7:0] data_p;
        if (!n_rst) begin
            stall_p = 1'b0;
            gap_p   = 1'b0;
        end else begin
            if (valid_bus != '0) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'(valid_bus), 0);
                end else begin
                    w = wr_q.pop_front();
                    chk("valid_bus", 32'(valid_bus),
                        32'(9'd1 << w.addr));
                    chk("master_data", 32'(master_data), 32'(w.data));
                end
            end
            if (err_addr) got_eaddr++;
            if (err_timeout) got_etmo++;
            if (stall_p)
                chk("tx_hold", {tx_valid, tx_data}, {1'b1, data_p});
            if (gap_p) chk("tx_gap", 32'(tx_valid), 0);
            if (tx_q.size() != 0 && !tx_q[0].first)
                chk("tx_bubble", 32'(tx_valid), 1);
            gap_p = 1'b0;
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    chk("unexpected_tx", 32'(tx_data), 32'hFFFF);
                end else begin
                    t = tx_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(t.b));
                    chk("rdreq", 32'(rdreq_bus),
                        t.pay ? 32'(9'd1 << t.slv) : 32'd0);
                    gap_p = t.last;
                end
            end else begin
                chk("rdreq_idle", 32'(rdreq_bus), 0);
            end
            stall_p = tx_valid && !tx_ready;
            data_p  = tx_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        zl[8] = 1'b1;
        n_rst = 1'b0;
        repeat (3) tick();
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_valid_bus", 32'(valid_bus), 0);
        chk("rst_master_data", 32'(master_data), 0);
        chk("rst_rdreq", 32'(rdreq_bus), 0);
        chk("rst_errs", {err_addr, err_timeout}, 0);
        n_rst = 1'b1;
        repeat (2) tick();

        send_pkt(8'd2, 1, 32'h5C, 0, 0);
        send_pkt(8'd0, 2, 32'h0703, 0, 1);
        send_pkt(8'd4, 0, 32'h0, 0, 0);
        rx_byte(8'h11, 0);
        send_pkt(8'h0C, 1, 32'hFF, 0, 0);
        send_pkt(8'd1, 1, 32'h03, 0, 0);

        rx_byte(SB, 0);
        rx_byte(8'h03, TMO);
        exp_etmo++;
        chk("timeout_pulse", got_etmo, exp_etmo);
        send_pkt(8'd3, 1, 32'h01, 0, 0);

        rx_byte(SB, 0);
        rx_byte(8'h04, 0);
        rx_byte(8'h01, TMO - 1);
        chk("timeout_edge", got_etmo, exp_etmo);
        wr_q.push_back('{addr: 8'd4, data: 8'h5A});
        rx_byte(8'h5A, 1);

        send_pkt(8'd6, 2, 32'hAAAA, 0, 1);
        send_pkt(SB, 1, 32'h12, 0, 0);
        send_pkt(8'd5, 1, 32'h77, 0, 0);

        rx_byte(SB, 0);
        rx_byte(8'h02, 0);
        rx_byte(8'h03, 0);
        wr_q.push_back('{addr: 8'd2, data: 8'h11});
        rx_byte(8'h11, 2);
        n_rst = 1'b0;
        tick();
        chk("rst_mid_vbus", 32'(valid_bus), 0);
        chk("rst_mid_mdata", 32'(master_data), 0);
        n_rst = 1'b1;
        tick();
        rx_byte(8'h22, 0);
        rx_byte(8'h33, 3);
        chk("wr_drain", wr_q.size(), 0);

        rdy_mode = 1;
        push_msg(5, 2, 0, 8'h3C, 8'h4D);
        schedule();
        wait_tx_done();

        rdy_mode = 2;
        for (int i = 0; i < 3; i++) begin
            push_msg(1, 1, 0, 8'h10 + 8'(i), 8'h00);
            push_msg(7, 1, 0, 8'h70 + 8'(i), 8'h00);
        end
        schedule();
        wait_tx_done();

        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        logic [7:0] g;
                        g = 8'($urandom);
                        if (g == SB) g = 8'h55;
                        rx_byte(g, 0);
                    end
                    send_pkt(8'($urandom_range(0, 11)),
                             $urandom_range(0, 4), 32'h0, 1, 2);
                end
            end
            begin
                for (int r = 0; r < 8; r++) begin
                    rdy_mode = $urandom_range(0, 2);
                    for (int m = 0; m < $urandom_range(1, 6); m++)
                        push_msg($urandom_range(0, 7),
                                 $urandom_range(1, 5), 1, 8'h0, 8'h0);
                    schedule();
                    wait_tx_done();
                end
            end
        join

        repeat (4) tick();
        chk("wr_drain_end", wr_q.size(), 0);
        chk("err_addr_count", got_eaddr, exp_eaddr);
        chk("err_timeout_count", got_etmo, exp_etmo);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
